// File: rtl/axi_i2s_transmitter.sv
`timescale 1ns/1ps
// axi_i2s_transmitter
//   Turns an AXI-Stream of stereo sample pairs (left beat, then right beat
//   marked with tlast) into a standard I2S serial stream. The I2S bit clock
//   and word select come from outside, are asynchronous, and are resampled
//   in the AXIS clock domain.
//
// Ports
//   s_axis_aclk      system clock, all logic on its rising edge
//   s_axis_aresetn   asynchronous active-low reset
//   s_axis_tvalid    AXIS beat valid
//   s_axis_tdata     one signed audio sample, sent MSB first
//   s_axis_tlast     marks the right-channel beat of a pair
//   s_axis_tready    AXIS beat ready
//   bclk             external I2S bit clock (<= aclk/8)
//   lrclk            external I2S word select, 0 = left, 1 = right
//   sdata_out        I2S serial data, updated shortly after bclk falls
module axi_i2s_transmitter #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_aresetn,
    input  logic                            s_axis_tvalid,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tlast,
    output logic                            s_axis_tready,
    input  logic                            bclk,
    input  logic                            lrclk,
    output logic                            sdata_out
);
    localparam int W = C_S_AXIS_TDATA_WIDTH;

    // bclk: two synchronizer flops plus one history flop for edge detection
    logic [2:0]   bclk_sync_q,  bclk_sync_d;
    logic [1:0]   lrclk_sync_q, lrclk_sync_d;
    logic         ws_cap_q,     ws_cap_d;
    logic         ws_prev_q,    ws_prev_d;
    logic [W-1:0] shift_q,      shift_d;
    logic [W-1:0] hold_q,       hold_d;
    logic [W-1:0] pend_l_q,     pend_l_d;
    logic [W-1:0] pend_r_q,     pend_r_d;
    logic         pend_l_full_q, pend_l_full_d;
    logic         pend_r_full_q, pend_r_full_d;
    logic         exp_r_q,      exp_r_d;   // next beat expected is right
    logic         run_q,        run_d;     // keeps tready low until out of reset

    logic bclk_rise, bclk_fall, word_start, axis_xfer;

    assign bclk_rise  = bclk_sync_q[1] & ~bclk_sync_q[2];
    assign bclk_fall  = ~bclk_sync_q[1] & bclk_sync_q[2];
    assign word_start = bclk_fall & (ws_cap_q != ws_prev_q);

    assign s_axis_tready = run_q & (exp_r_q ? ~pend_r_full_q : ~pend_l_full_q);
    assign axis_xfer     = s_axis_tvalid & s_axis_tready;
    assign sdata_out     = shift_q[W-1];

    always_comb begin
        bclk_sync_d   = {bclk_sync_q[1:0], bclk};
        lrclk_sync_d  = {lrclk_sync_q[0], lrclk};
        run_d         = 1'b1;
        ws_cap_d      = ws_cap_q;
        ws_prev_d     = ws_prev_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        pend_l_d      = pend_l_q;
        pend_r_d      = pend_r_q;
        pend_l_full_d = pend_l_full_q;
        pend_r_full_d = pend_r_full_q;
        exp_r_d       = exp_r_q;

        if (bclk_rise) begin
            ws_cap_d = lrclk_sync_q[1];
        end

        if (bclk_fall) begin
            ws_prev_d = ws_cap_q;
            if (word_start) begin
                if (!ws_cap_q) begin
                    // Left word: a frame only carries data when the whole pair
                    // is present, so L and R always leave together.
                    if (pend_l_full_q && pend_r_full_q) begin
                        shift_d       = pend_l_q;
                        hold_d        = pend_r_q;
                        pend_l_full_d = 1'b0;
                        pend_r_full_d = 1'b0;
                    end else begin
                        shift_d = '0;
                        hold_d  = '0;
                    end
                end else begin
                    shift_d = hold_q;
                    hold_d  = '0;
                end
            end else begin
                // Zero fill: long half-frames pad with zeros after the LSB.
                shift_d = {shift_q[W-2:0], 1'b0};
            end
        end

        // Applied after the load so a beat landing in the same cycle survives.
        if (axis_xfer) begin
            if (s_axis_tlast) begin
                pend_r_d      = s_axis_tdata;
                pend_r_full_d = 1'b1;
                exp_r_d       = 1'b0;
            end else begin
                pend_l_d      = s_axis_tdata;
                pend_l_full_d = 1'b1;
                exp_r_d       = 1'b1;
            end
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            bclk_sync_q   <= '0;
            lrclk_sync_q  <= '0;
            ws_cap_q      <= 1'b0;
            ws_prev_q     <= 1'b0;
            shift_q       <= '0;
            hold_q        <= '0;
            pend_l_q      <= '0;
            pend_r_q      <= '0;
            pend_l_full_q <= 1'b0;
            pend_r_full_q <= 1'b0;
            exp_r_q       <= 1'b0;
            run_q         <= 1'b0;
        end else begin
            bclk_sync_q   <= bclk_sync_d;
            lrclk_sync_q  <= lrclk_sync_d;
            ws_cap_q      <= ws_cap_d;
            ws_prev_q     <= ws_prev_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            pend_l_q      <= pend_l_d;
            pend_r_q      <= pend_r_d;
            pend_l_full_q <= pend_l_full_d;
            pend_r_full_q <= pend_r_full_d;
            exp_r_q       <= exp_r_d;
            run_q         <= run_d;
        end
    end

endmodule

// File: tb/tb_axi_i2s_transmitter.sv
`timescale 1ns/1ps
// Bench for axi_i2s_transmitter: an I2S clock master and receiver live in the
// bench; received words are compared with sent pairs, truncated or
// zero-padded to the half-frame length.
module tb_axi_i2s_transmitter;
    localparam int W  = 32;
    localparam int BH = 40;    // half bclk period in ns (bclk = aclk/8)
    localparam int NP = 120;   // random pairs

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic         tvalid = 1'b0;
    logic         tlast = 1'b0;
    logic [W-1:0] tdata = '0;
    logic         tready;
    logic         bclk = 1'b1;
    logic         lrclk = 1'b1;
    logic         sdata;

    int n_checks = 0;
    int n_errors = 0;
    bit abort = 0;

    logic [63:0]  rx_w[$];
    int           rx_n[$];
    logic [63:0]  cur;
    int           cur_n;
    bit           have_cur;
    logic [W-1:0] exp_l[$], exp_r[$];

    always #5 aclk = ~aclk;

    axi_i2s_transmitter #(.C_S_AXIS_TDATA_WIDTH(W)) dut (
        .s_axis_aclk    (aclk),
        .s_axis_aresetn (aresetn),
        .s_axis_tvalid  (tvalid),
        .s_axis_tdata   (tdata),
        .s_axis_tlast   (tlast),
        .s_axis_tready  (tready),
        .bclk           (bclk),
        .lrclk          (lrclk),
        .sdata_out      (sdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // What an I2S receiver sees in an n-bclk slot: MSB first, then zeros.
    function automatic logic [63:0] exp_bits(input logic [W-1:0] w, input int n);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < n; k++) begin
            if (k < W) r = {r[62:0], w[W-1-k]};
            else       r = {r[62:0], 1'b0};
        end
        return r;
    endfunction

    task automatic take_bit(input logic b);
        cur = {cur[62:0], b};
        cur_n++;
    endtask

    task automatic close_word();
        if (have_cur) begin
            rx_w.push_back(cur);
            rx_n.push_back(cur_n);
        end
        cur = '0;
        cur_n = 0;
        have_cur = 1;
    endtask

    // The bit sampled on the first rise of a half-frame still belongs to the
    // previous word (one-bclk I2S delay).
    task automatic half_frame(input logic ch, input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b0;
            if (i == 0) lrclk = ch;
            #BH;
            if (i == 0) begin
                if (have_cur) take_bit(sdata);
                close_word();
            end else begin
                take_bit(sdata);
            end
            bclk = 1'b1;
            #BH;
        end
    endtask

    // len == 0 picks a random 4..40 length for each half-frame.
    task automatic run_frames(input int nfr, input int len);
        int nl, nr;
        rx_w.delete();
        rx_n.delete();
        have_cur = 0;
        @(posedge aclk);
        #2;
        for (int f = 0; f < nfr; f++) begin
            nl = (len > 0) ? len : int'($urandom_range(40, 4));
            nr = (len > 0) ? len : int'($urandom_range(40, 4));
            half_frame(1'b0, nl);
            half_frame(1'b1, nr);
        end
        bclk = 1'b0;
        #BH;
        take_bit(sdata);
        close_word();
        have_cur = 0;
        bclk = 1'b1;
        #BH;
    endtask

    task automatic chk_frame(input string tag, input int k, input logic [W-1:0] l, input logic [W-1:0] r);
        if (rx_w.size() < 2*k + 2) begin
            chk({tag, "_words"}, rx_w.size(), 2*k + 2);
            return;
        end
        chk({tag, "_l"}, rx_w[2*k],   exp_bits(l, rx_n[2*k]));
        chk({tag, "_r"}, rx_w[2*k+1], exp_bits(r, rx_n[2*k+1]));
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic last);
        int   t;
        logic ok;
        t = 0;
        ok = 1'b0;
        if (abort) return;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        do begin
            @(negedge aclk);
            ok = tready;
            @(posedge aclk);
            t++;
        end while (!ok && t < 2000);
        #1;
        tvalid = 1'b0;
        if (!ok) begin
            chk("axis_timeout", t, 0);
            abort = 1;
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] a, b, l, r;
        int k;

        // reset state and first cycle after release
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tready", tready, 0);
        chk("rst_sdata", sdata, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        chk("tready_after_rst", tready, 1);

        // 32-bclk frames, known pair, then idle frames
        send_beat(32'hA5A5_0F0F, 1'b0);
        send_beat(32'h1234_5678, 1'b1);
        repeat (5) @(posedge aclk);
        #1;
        chk("tready_pair_full", tready, 0);
        run_frames(3, 32);
        chk_frame("f32", 0, 32'hA5A5_0F0F, 32'h1234_5678);
        chk("f32_l_raw", rx_w[0], 64'hA5A5_0F0F);
        chk_frame("f32_idle1", 1, '0, '0);
        chk_frame("f32_idle2", 2, '0, '0);

        // 40-bclk frames pad with zeros
        b = $urandom;
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(b, 1'b1);
        run_frames(2, 40);
        chk_frame("f40", 0, 32'hFFFF_FFFF, b);
        chk("f40_l_raw", rx_w[0], 64'hFF_FFFF_FF00);

        // 4-bclk frames truncate, later frames intact
        b = $urandom;
        send_beat(32'hC000_0000, 1'b0);
        send_beat(b, 1'b1);
        run_frames(2, 4);
        chk_frame("f4", 0, 32'hC000_0000, b);
        chk("f4_l_raw", rx_w[0], 64'hC);
        chk_frame("f4_idle", 1, '0, '0);
        a = $urandom;
        b = $urandom;
        send_beat(a, 1'b0);
        send_beat(b, 1'b1);
        run_frames(2, 32);
        chk_frame("f4_after", 0, a, b);
        chk_frame("f4_after_idle", 1, '0, '0);

        // right beat while left expected is taken as right
        a = $urandom;
        b = $urandom;
        send_beat(b, 1'b1);
        send_beat(a, 1'b0);
        repeat (3) @(posedge aclk);
        #1;
        chk("resync_tready", tready, 0);
        run_frames(1, 32);
        chk_frame("resync", 0, a, b);

        // no data, random frame lengths
        run_frames(3, 0);
        for (int f = 0; f < 3; f++) chk_frame("nodata", f, '0, '0);

        // reset mid left word
        b = $urandom | 32'h8000_0000;
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(b, 1'b1);
        fork
            run_frames(3, 32);
            begin
                #(BH*2*12);
                chk("mid_pre_sdata", sdata, 1);
                aresetn = 1'b0;
                #1;
                chk("mid_rst_sdata", sdata, 0);
                chk("mid_rst_tready", tready, 0);
                #50;
                aresetn = 1'b1;
            end
        join
        chk_frame("post_rst_idle1", 1, '0, '0);
        chk_frame("post_rst_idle2", 2, '0, '0);
        a = $urandom;
        b = $urandom;
        send_beat(a, 1'b0);
        send_beat(b, 1'b1);
        run_frames(2, 32);
        chk_frame("resume", 0, a, b);

        // continuous producer against random frames
        fork
            begin
                for (int p = 0; p < NP; p++) begin
                    l = $urandom | 32'h8000_0000;
                    r = $urandom | 32'h8000_0000;
                    exp_l.push_back(l);
                    exp_r.push_back(r);
                    send_beat(l, 1'b0);
                    send_beat(r, 1'b1);
                end
            end
            run_frames(NP + 4, 0);
        join
        k = 0;
        for (int f = 0; f < NP + 4; f++) begin
            if (rx_w[2*f] == 0 && rx_w[2*f+1] == 0) begin
                if (k > 0 && k < NP) chk("rnd_gap", k, NP);
            end else if (k < NP) begin
                chk("rnd_l", rx_w[2*f],   exp_bits(exp_l[k], rx_n[2*f]));
                chk("rnd_r", rx_w[2*f+1], exp_bits(exp_r[k], rx_n[2*f+1]));
                k++;
            end else begin
                chk("rnd_extra", rx_w[2*f], 0);
            end
        end
        chk("rnd_count", k, NP);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
